// File: rtl/fft_in_packer.sv
// fft_in_packer: ping-pong frame buffer that turns a one-sample-per-cycle stream
// into uninterrupted 32-beat x 16-lane bursts for the parallel FFT input port.
module fft_in_packer #(
    parameter int IN_WIDTH = 9,
    parameter int NUM = 16,
    parameter int FRAME = 512
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [IN_WIDTH-1:0] s_i,
    input  logic signed [IN_WIDTH-1:0] s_q,
    input  logic                       s_last,
    output logic                       valid_out,
    output logic signed [IN_WIDTH-1:0] dout_i [0:NUM-1],
    output logic signed [IN_WIDTH-1:0] dout_q [0:NUM-1],
    output logic                       frame_err
);
    localparam int ROWS = FRAME / NUM;
    localparam int LW = $clog2(NUM);
    localparam int RW = $clog2(ROWS);
    localparam int SW = 2 * IN_WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    logic [NUM-1:0][SW-1:0] mem [0:2*ROWS-1];
    logic [NUM-1:0][SW-1:0] row_buf, wr_word, rd_word;
    logic [LW-1:0] lane_cnt;
    logic [RW-1:0] row_cnt, rd_row, rd_addr;
    logic [1:0] full;
    logic wr_bank, rd_bank;
    state_t state, state_n;
    logic accept, at_last, row_done, frame_done, early_last, burst_end, valid_n;

    assign s_ready = !full[wr_bank];
    assign accept = s_valid && s_ready;
    assign at_last = lane_cnt == LAST_LANE && row_cnt == LAST_ROW;
    assign row_done = accept && lane_cnt == LAST_LANE;
    assign frame_done = accept && at_last;
    assign early_last = accept && s_last && !at_last;

    // The incoming sample completes the row, so it bypasses the row register.
    always_comb begin
        wr_word = row_buf;
        wr_word[NUM-1] = {s_i, s_q};
    end

    always_ff @(posedge clk) begin
        if (accept) row_buf[lane_cnt] <= {s_i, s_q};
        if (row_done) mem[{wr_bank, row_cnt}] <= wr_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt <= '0;
            row_cnt <= '0;
            wr_bank <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && (s_last != at_last);
            if (early_last || frame_done) begin
                lane_cnt <= '0;
                row_cnt <= '0;
            end else if (accept) begin
                lane_cnt <= lane_cnt + 1'b1;
                if (row_done) row_cnt <= row_cnt + 1'b1;
            end
            if (frame_done) wr_bank <= !wr_bank;
        end
    end

    // Writer and reader always own different banks, so set and clear never collide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= '0;
        end else begin
            if (burst_end) full[rd_bank] <= 1'b0;
            if (frame_done) full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            rd_row <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_n;
            rd_row <= rd_addr;
            if (burst_end) rd_bank <= !rd_bank;
        end
    end

    always_comb begin
        state_n = state == IDLE ? (full[rd_bank] ? BURST : IDLE)
                                : (rd_row == LAST_ROW ? IDLE : BURST);
    end

    // Row about to be shown is read combinationally straight into the output register.
    always_comb begin
        burst_end = state == BURST && rd_row == LAST_ROW;
        rd_addr = state == IDLE ? '0 : rd_row + 1'b1;
        valid_n = state_n == BURST;
    end

    assign rd_word = mem[{rd_bank, rd_addr}];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                dout_i[l] <= '0;
                dout_q[l] <= '0;
            end
        end else begin
            valid_out <= valid_n;
            for (int l = 0; l < NUM; l++) begin
                dout_i[l] <= valid_n ? rd_word[l][SW-1 -: IN_WIDTH] : '0;
                dout_q[l] <= valid_n ? rd_word[l][IN_WIDTH-1:0] : '0;
            end
        end
    end
endmodule

// File: tb/tb_fft_in_packer.sv
// tb_fft_in_packer: random and directed frames checked against a frame-level
// queue model of what the packer must emit and when.
module tb_fft_in_packer;
    localparam int W = 9;
    localparam int N = 16;
    localparam int F = 512;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic signed [W-1:0] s_i = '0;
    logic signed [W-1:0] s_q = '0;
    logic s_ready, valid_out, frame_err;
    logic signed [W-1:0] dout_i [0:N-1];
    logic signed [W-1:0] dout_q [0:N-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beat = -1;
    logic exp_err = 1'b0;
    logic abort = 1'b0;
    logic [2*W-1:0] cur[$];
    logic [2*W-1:0] exp_s[$];
    int done_q[$];

    fft_in_packer #(.IN_WIDTH(W), .NUM(N), .FRAME(F)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_i(s_i), .s_q(s_q), .s_last(s_last), .valid_out(valid_out),
        .dout_i(dout_i), .dout_q(dout_q), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] clip(input int v);
        return W'(v > 255 ? 255 : (v < -256 ? -256 : v));
    endfunction

    function automatic logic dout_zero();
        logic z;
        z = 1'b1;
        for (int l = 0; l < N; l++) z = z && (dout_i[l] === '0) && (dout_q[l] === '0);
        return z;
    endfunction

    // Frame-level model: a frame is whatever 512 samples follow the last resync.
    task automatic model_accept(input logic [W-1:0] si, input logic [W-1:0] sq, input logic sl);
        cur.push_back({si, sq});
        if (cur.size() == F) begin
            foreach (cur[k]) exp_s.push_back(cur[k]);
            done_q.push_back(cyc);
            exp_err = !sl;
            cur.delete();
        end else if (sl) begin
            exp_err = 1'b1;
            cur.delete();
        end
    endtask

    task automatic monitor();
        if (valid_out) begin
            if (beat < 0) begin
                checks++;
                assert (done_q.size() > 0 && cyc - done_q[0] == 1) else begin
                    errors++;
                    $error("FAIL burst_start cyc %0d pending %0d", cyc, done_q.size());
                end
                beat = 0;
            end
            if (beat >= F / N || exp_s.size() < F) begin
                checks++;
                errors++;
                $error("FAIL extra_beat beat %0d queued %0d exp none", beat, exp_s.size());
            end else begin
                for (int l = 0; l < N; l++) begin
                    checks++;
                    assert ({dout_i[l], dout_q[l]} === exp_s[beat*N+l]) else begin
                        errors++;
                        $error("FAIL beat%0d_lane%0d got %h exp %h", beat, l, {dout_i[l], dout_q[l]}, exp_s[beat*N+l]);
                    end
                end
            end
            beat++;
        end else begin
            checks++;
            assert (dout_zero() === 1'b1) else begin
                errors++;
                $error("FAIL dout_idle got nonzero exp 0 at cyc %0d", cyc);
            end
            if (beat >= 0) begin
                checks++;
                assert (beat == F / N) else begin
                    errors++;
                    $error("FAIL burst_len got %0d exp %0d", beat, F / N);
                end
                repeat (F) if (exp_s.size() > 0) void'(exp_s.pop_front());
                if (done_q.size() > 0) void'(done_q.pop_front());
                beat = -1;
            end
        end
    endtask

    task automatic tick(output logic acc);
        acc = s_valid && s_ready;
        checks++;
        assert (s_ready === 1'b1) else begin
            errors++;
            $error("FAIL s_ready got %b exp 1 at cyc %0d", s_ready, cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_err = 1'b0;
        if (acc) model_accept(s_i, s_q, s_last);
        checks++;
        assert (frame_err === exp_err) else begin
            errors++;
            $error("FAIL frame_err cyc %0d got %b exp %b", cyc, frame_err, exp_err);
        end
        monitor();
    endtask

    task automatic send(input int n, input int last_at, input int gap, input bit ramp);
        logic acc;
        int tries;
        for (int k = 0; k < n && !abort; k++) begin
            s_i = ramp ? clip(k - 256) : W'($urandom);
            s_q = ramp ? clip(256 - k) : W'($urandom);
            s_last = (k == last_at);
            tries = 0;
            acc = 1'b0;
            while (!acc && !abort) begin
                s_valid = ($urandom_range(99) >= gap);
                tick(acc);
                tries++;
                if (!acc && tries >= 200) begin
                    checks++;
                    errors++;
                    abort = 1'b1;
                    $error("FAIL accept_timeout sample %0d got no handshake exp one within 200 cycles", k);
                end
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (n) tick(a);
    endtask

    initial begin
        logic a;
        int t;
        #12;
        checks++;
        assert (valid_out === 1'b0 && frame_err === 1'b0 && dout_zero() === 1'b1) else begin
            errors++;
            $error("FAIL reset_out got v=%b e=%b exp 0", valid_out, frame_err);
        end
        checks++;
        assert (s_ready === 1'b1) else begin
            errors++;
            $error("FAIL reset_ready got %b exp 1", s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        idle(3);

        send(F, F - 1, 0, 1'b1);
        idle(40);

        repeat (4) send(F, F - 1, 0, 1'b0);
        idle(40);

        repeat (2) send(F, F - 1, 50, 1'b0);
        idle(40);

        send(101, 100, 0, 1'b0);
        send(F, F - 1, 0, 1'b0);
        idle(40);

        send(F, -1, 0, 1'b0);
        idle(40);

        send(F, F - 1, 0, 1'b1);
        t = 0;
        while (beat != 11 && t < 100) begin
            tick(a);
            t++;
        end
        checks++;
        assert (beat == 11) else begin
            errors++;
            $error("FAIL beat10_wait got beat %0d exp 11", beat);
        end
        rstn = 1'b0;
        #1;
        checks++;
        assert (valid_out === 1'b0 && dout_zero() === 1'b1 && s_ready === 1'b1) else begin
            errors++;
            $error("FAIL async_reset got v=%b r=%b exp v=0 r=1", valid_out, s_ready);
        end
        beat = -1;
        exp_s.delete();
        done_q.delete();
        cur.delete();
        @(posedge clk);
        #1;
        checks++;
        assert (valid_out === 1'b0 && frame_err === 1'b0) else begin
            errors++;
            $error("FAIL held_reset got v=%b e=%b exp 0", valid_out, frame_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        idle(40);
        send(F, F - 1, 0, 1'b0);
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
